vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   VGA raster timing generator for the 640x480@60 display path. It sits directly downstream of
//   the 100->25 MHz divider and advances one pixel per pix_tick strobe.
//   Produces hsync/vsync, the visible-area flag and the current pixel coordinates.
//   The snake renderer consumes these to choose the colour of each pixel.
// PARAMETERS
//   H_VISIBLE  640  active pixels per line
//   H_FP       16   horizontal front porch (pixels)
//   H_SYNC     96   horizontal sync width (pixels)
//   H_BP       48   horizontal back porch (pixels); H_TOTAL = sum = 800
//   V_VISIBLE  480  active lines per frame
//   V_FP       10   vertical front porch (lines)
//   V_SYNC     2    vertical sync width (lines)
//   V_BP       33   vertical back porch (lines); V_TOTAL = sum = 525
//   SYNC_POL   0    sync active level (0 = active-low, as 640x480 requires)
// PORTS
//   clk         in   1   system clock; one clock domain
//   reset       in   1   synchronous, active-high reset
//   pix_tick    in   1   pixel-advance strobe (divider output); tie to 1 to advance every clk
//   hsync       out  1   horizontal sync, level per SYNC_POL
//   vsync       out  1   vertical sync, level per SYNC_POL
//   video_on    out  1   1 while (pix_x < H_VISIBLE) && (pix_y < V_VISIBLE)
//   pix_x       out  10  horizontal counter, 0..H_TOTAL-1
//   pix_y       out  10  vertical counter, 0..V_TOTAL-1
//   frame_tick  out  1   one-clk pulse on the edge where the counters wrap to (0,0)
// BEHAVIOUR
//   - Reset: h_cnt = v_cnt = 0, pix_x = pix_y = 0, hsync = vsync = inactive (~SYNC_POL),
//     video_on = 0, frame_tick = 0. pix_tick is ignored while reset = 1.
//   - Reset mid-frame: returns to these values on the next edge; no partial-line recovery.
//   - Counters change only on an edge where pix_tick = 1; otherwise every output holds.
//   - h_cnt counts 0..H_TOTAL-1. Wrap: at H_TOTAL-1 it returns to 0 and v_cnt advances.
//   - v_cnt counts 0..V_TOTAL-1. Wrap: at V_TOTAL-1 together with the h wrap, it returns to 0.
//   - Output timing: all outputs are registered and decoded from the counters' next-state values.
//     They change on the same edge as the counters, with zero skew to pix_x/pix_y.
//   - Sync windows: hsync is active for h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751].
//     vsync is active for v in [490,491].
//   - frame_tick = 1 for exactly one clk, on the pix_tick edge taking (799,524) to (0,0).
//     It is 0 on every other edge, including reset release.
//   - After reset, video_on stays 0 until the first pix_tick moves the counters to (1,0).
//     Pixel (0,0) of the first frame is therefore dark; this is accepted.
//   - Arithmetic: unsigned 10-bit compares; parameter sums must fit in 10 bits.
// CONFIGURATION
//   VGA_FRAME_CNT_EN defined:
//     - adds output frame_cnt [15:0]; reset value 0.
//     - frame_cnt increments on every frame_tick and wraps 65535 -> 0.
//     - the game logic uses it as a frame-rate timebase.
//   VGA_FRAME_CNT_EN undefined: the port and its register are absent; all other behaviour is identical.
// STRUCTURE
//   - Package vga_timing_pkg: 640x480 timing localparams, H_TOTAL/V_TOTAL, sync window bounds,
//     and the coordinate width (10).
//   - Sub-module vga_axis_counter (MAX, width): counter with enable, a wrap output,
//     and next-value output. It is instantiated twice: h with en = pix_tick,
//     v with en = pix_tick & h_wrap.
// TESTING
//   1. reset = 1 for 3 clks, pix_tick = 1
//      -> pix_x = pix_y = 0, hsync = vsync = 1, video_on = 0, frame_tick = 0.
//   2. pix_tick asserted 1 clk in 4
//      -> the counters advance once per 4 clks; outputs are stable on non-tick clks.
//   3. pix_tick = 1 continuously, one line
//      -> hsync = 0 exactly at pix_x 656..751 (96 ticks); video_on = 0 from pix_x = 640.
//   4. Run a full frame (420000 ticks)
//      -> vsync = 0 on lines 490..491 only; frame_tick pulses once, at (799,524) -> (0,0).
//   5. Assert reset at pix_x = 300, pix_y = 200
//      -> the next clk shows pix_x = pix_y = 0 and all outputs at reset values.
//   6. With VGA_FRAME_CNT_EN: run 3 frames -> frame_cnt = 3. Without it: the module elaborates
//      with no frame_cnt port.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster timing constants, coordinate type and window helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package vga_timing_pkg;

  // Coordinate width shared by both axes; every timing sum below must fit in it.
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal timing, in pixels.
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800

  // Vertical timing, in lines.
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525

  // Inclusive sync windows: hsync [656,751], vsync [490,491].
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Active sync level: 640x480 uses negative-going syncs.
  localparam logic SYNC_POL = 1'b0;

  // Unsigned inclusive range test used for the sync windows.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: modulo-MAX counter with enable, terminal-count flag and next-value output.
// Latency: cnt follows nxt one clk later; nxt and wrap are combinational from cnt/en.
// Backpressure: none; the count simply holds while en = 0.
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int MAX   = H_TOTAL,
  parameter int WIDTH = COORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  // Terminal count and the value the counter takes on the next edge (reset excluded,
  // so the parent can decode "where the raster goes next" independently of reset).
  always_comb begin
    wrap = (cnt == LAST);
    nxt  = cnt;
    if (en) begin
      nxt = wrap ? '0 : cnt + 1'b1;
    end
  end

  // Count register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster generator; hsync/vsync, video_on, pixel coords, frame_tick.
// Latency: all outputs registered, decoded from next counter values, zero skew to pix_x/pix_y.
// Backpressure: none; pix_tick = 0 holds every output (frame_tick drops to 0). Option: VGA_FRAME_CNT_EN adds frame_cnt.
module vga_sync_gen #(
  parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FP      = vga_timing_pkg::H_FP,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BP      = vga_timing_pkg::H_BP,
  parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FP      = vga_timing_pkg::V_FP,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BP      = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  import vga_timing_pkg::*;

  // Derived raster geometry for this parameter set.
  localparam int     LINE_LEN  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int     FRAME_LEN = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam coord_t HS_LO     = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_HI     = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO     = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_HI     = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t H_VIS     = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS     = coord_t'(V_VISIBLE);

  coord_t h_cnt, h_nxt;
  coord_t v_cnt, v_nxt;
  logic   h_wrap, v_wrap;
  logic   v_en;
  logic   frame_wrap;
  logic   hsync_nxt, vsync_nxt, video_nxt;

  // The line counter steps every pixel; the frame counter steps only when a line ends.
  assign v_en = pix_tick & h_wrap;

  vga_axis_counter #(
    .MAX   (LINE_LEN),
    .WIDTH (COORD_W)
  ) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_tick),
    .cnt   (h_cnt),
    .nxt   (h_nxt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .MAX   (FRAME_LEN),
    .WIDTH (COORD_W)
  ) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .cnt   (v_cnt),
    .nxt   (v_nxt),
    .wrap  (v_wrap)
  );

  // The counters are the coordinate registers, so coordinates and decoded outputs
  // update on the same edge.
  assign pix_x = h_cnt;
  assign pix_y = v_cnt;

  // Decode sync/visible from where the counters are going, so the registered flags
  // line up with the registered coordinates.
  always_comb begin
    hsync_nxt  = ~SYNC_POL;
    vsync_nxt  = ~SYNC_POL;
    video_nxt  = 1'b0;
    frame_wrap = 1'b0;
    if (in_window(h_nxt, HS_LO, HS_HI)) begin
      hsync_nxt = SYNC_POL;
    end
    if (in_window(v_nxt, VS_LO, VS_HI)) begin
      vsync_nxt = SYNC_POL;
    end
    video_nxt  = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    frame_wrap = pix_tick & h_wrap & v_wrap;
  end

  // Output registers: hold between ticks; frame_tick is a single-clk pulse on the wrap edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      video_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (pix_tick) begin
        hsync    <= hsync_nxt;
        vsync    <= vsync_nxt;
        video_on <= video_nxt;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Free-running frame counter for game timebase; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks vga_sync_gen at full 640x480 timing and at a shrunken timing
// so whole frames fit in a short run. Reference model derives everything from a tick count.
// Table vectors, hand-written corner sequences, then randomized pix_tick/reset traffic.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_tick = 1'b0;

  always #5 clk = ~clk;

  // Full-size instance.
  logic       hs0, vs0, vo0, ft0;
  logic [9:0] x0, y0;
  // Shrunken instance: 16 x 12 raster, 192 ticks per frame.
  logic       hs1, vs1, vo1, ft1;
  logic [9:0] x1, y1;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc0, fc1;
`endif

  vga_sync_gen dut (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick),
    .hsync      (hs0),
    .vsync      (vs0),
    .video_on   (vo0),
    .pix_x      (x0),
    .pix_y      (y0),
    .frame_tick (ft0)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (fc0)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
    .SYNC_POL  (1'b0)
  ) dut_s (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick),
    .hsync      (hs1),
    .vsync      (vs1),
    .video_on   (vo1),
    .pix_x      (x1),
    .pix_y      (y1),
    .frame_tick (ft1)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (fc1)
`endif
  );

  // ---------------- reference model ----------------
  int P_HV[2] = '{640, 8};
  int P_HF[2] = '{16, 2};
  int P_HS[2] = '{96, 3};
  int P_HB[2] = '{48, 3};
  int P_VV[2] = '{480, 6};
  int P_VF[2] = '{10, 2};
  int P_VS[2] = '{2, 2};
  int P_VB[2] = '{33, 2};

  int   m_n[2];      // pixel ticks since the last reset
  logic m_ft[2];     // frame_tick expected this cycle
  bit   model_ok = 0;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int line_len(int d);
    return P_HV[d] + P_HF[d] + P_HS[d] + P_HB[d];
  endfunction

  function automatic int frame_len(int d);
    return line_len(d) * (P_VV[d] + P_VF[d] + P_VS[d] + P_VB[d]);
  endfunction

  // Raster position is simply tick count modulo the line/frame lengths.
  function automatic logic [23:0] model_out(int d);
    int   x, y, hlo, vlo;
    logic hs, vs, vo;
    x   = m_n[d] % line_len(d);
    y   = (m_n[d] / line_len(d)) % (P_VV[d] + P_VF[d] + P_VS[d] + P_VB[d]);
    hlo = P_HV[d] + P_HF[d];
    vlo = P_VV[d] + P_VF[d];
    hs  = !((x >= hlo) && (x < hlo + P_HS[d]));
    vs  = !((y >= vlo) && (y < vlo + P_VS[d]));
    vo  = (m_n[d] > 0) && (x < P_HV[d]) && (y < P_VV[d]);
    return {10'(x), 10'(y), hs, vs, vo, m_ft[d]};
  endfunction

  function automatic logic [23:0] obs(int d);
    if (d == 0) return {x0, y0, hs0, vs0, vo0, ft0};
    return {x1, y1, hs1, vs1, vo1, ft1};
  endfunction

  task automatic check(string name, logic [23:0] got, logic [23:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got x=%0d y=%0d hs/vs/vo/ft=%b, expected x=%0d y=%0d hs/vs/vo/ft=%b (t=%0t)",
               name, got[23:14], got[13:4], got[3:0], exp[23:14], exp[13:4], exp[3:0], $time);
    else
      n_pass++;
  endtask

  task automatic check_int(string name, int got, int exp);
    n_checks++;
    if (got != exp)
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    else
      n_pass++;
  endtask

  // Drive one clk of stimulus, advance the model, compare both instances.
  task automatic step(logic r, logic t);
    reset    = r;
    pix_tick = t;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_n[d]  = 0;
        m_ft[d] = 1'b0;
      end else if (t) begin
        m_n[d]  = m_n[d] + 1;
        m_ft[d] = ((m_n[d] % frame_len(d)) == 0);
      end else begin
        m_ft[d] = 1'b0;
      end
    end
    if (r) model_ok = 1;
    if (model_ok) begin
      check("model_full", obs(0), model_out(0));
      check("model_small", obs(1), model_out(1));
`ifdef VGA_FRAME_CNT_EN
      check_int("frame_cnt_small", int'(fc1), (m_n[1] / frame_len(1)) % 65536);
      check_int("frame_cnt_full", int'(fc0), (m_n[0] / frame_len(0)) % 65536);
`endif
    end
  endtask

  // ---------------- table vectors (full-size instance) ----------------
  typedef struct {
    logic        rst;
    logic        tick;
    logic [23:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic t, int x, int y, logic hs, logic vs, logic vo, logic ft);
    vec_t v;
    v.rst  = r;
    v.tick = t;
    v.exp  = {10'(x), 10'(y), hs, vs, vo, ft};
    return v;
  endfunction

  localparam logic [23:0] RESET_VEC = {10'd0, 10'd0, 4'b1100};

  initial begin
    vec_t vecs[15];
    int   lo_cnt, lo_min, lo_max, vo_off;
    int   pulses, vs_cnt, vs_min, vs_max;
    logic [23:0] prev1, at_pulse;

    // Reset with pix_tick held high, then 1-in-4 ticking, then a reset mid-stream.
    vecs[0]  = mk(1, 1, 0, 0, 1, 1, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 1, 1, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 1, 0, 0);
    vecs[4]  = mk(0, 1, 1, 0, 1, 1, 1, 0);
    vecs[5]  = mk(0, 0, 1, 0, 1, 1, 1, 0);
    vecs[6]  = mk(0, 0, 1, 0, 1, 1, 1, 0);
    vecs[7]  = mk(0, 0, 1, 0, 1, 1, 1, 0);
    vecs[8]  = mk(0, 1, 2, 0, 1, 1, 1, 0);
    vecs[9]  = mk(0, 0, 2, 0, 1, 1, 1, 0);
    vecs[10] = mk(0, 0, 2, 0, 1, 1, 1, 0);
    vecs[11] = mk(0, 0, 2, 0, 1, 1, 1, 0);
    vecs[12] = mk(0, 1, 3, 0, 1, 1, 1, 0);
    vecs[13] = mk(1, 0, 0, 0, 1, 1, 0, 0);
    vecs[14] = mk(0, 1, 1, 0, 1, 1, 1, 0);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].tick);
      check($sformatf("vec%0d", i), obs(0), vecs[i].exp);
    end

    // Strict 1-in-4 ticking: counters advance once per 4 clks, hold otherwise.
    for (int i = 0; i < 40; i++) step(0, (i % 4) == 3);

    // One full line at continuous tick on the full-size instance.
    step(1, 1);
    lo_cnt = 0; lo_min = 9999; lo_max = -1; vo_off = -1;
    for (int i = 0; i < 800; i++) begin
      step(0, 1);
      if (hs0 == 1'b0) begin
        lo_cnt++;
        if (int'(x0) < lo_min) lo_min = int'(x0);
        if (int'(x0) > lo_max) lo_max = int'(x0);
      end
      if (!vo0 && vo_off < 0) vo_off = int'(x0);
    end
    check_int("hsync_low_ticks", lo_cnt, 96);
    check_int("hsync_first_x", lo_min, 656);
    check_int("hsync_last_x", lo_max, 751);
    check_int("video_off_x", vo_off, 640);
    check("line_wrap", obs(0), {10'd0, 10'd1, 4'b1110});

    // Full frame plus a little on the small instance: one pulse, at (15,11)->(0,0).
    step(1, 1);
    pulses = 0; vs_cnt = 0; vs_min = 9999; vs_max = -1;
    prev1 = obs(1); at_pulse = '0;
    for (int i = 0; i < 200; i++) begin
      step(0, 1);
      if (ft1) begin
        pulses++;
        at_pulse = prev1;
        check("frame_wrap_pos", obs(1), {10'd0, 10'd0, 4'b1111});
      end
      if (vs1 == 1'b0) begin
        vs_cnt++;
        if (int'(y1) < vs_min) vs_min = int'(y1);
        if (int'(y1) > vs_max) vs_max = int'(y1);
      end
      prev1 = obs(1);
    end
    check_int("frame_pulses", pulses, 1);
    check_int("pre_wrap_x", int'(at_pulse[23:14]), 15);
    check_int("pre_wrap_y", int'(at_pulse[13:4]), 11);
    check_int("vsync_low_ticks", vs_cnt, 32);
    check_int("vsync_first_line", vs_min, 8);
    check_int("vsync_last_line", vs_max, 9);

    // Reset mid-frame: park the small raster at (5,4), then reset with tick still high.
    step(1, 1);
    for (int i = 0; i < 69; i++) step(0, 1);
    check("mid_frame_pos", obs(1), {10'd5, 10'd4, 4'b1110});
    step(1, 1);
    check("reset_mid_small", obs(1), RESET_VEC);
    check("reset_mid_full", obs(0), RESET_VEC);

    // Three frames on the small raster.
    step(1, 1);
    pulses = 0;
    for (int i = 0; i < 3 * 192; i++) begin
      step(0, 1);
      if (ft1) pulses++;
    end
    check_int("three_frame_pulses", pulses, 3);
`ifdef VGA_FRAME_CNT_EN
    check_int("frame_cnt_3", int'(fc1), 3);
`endif

    // Randomized ticking with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
